// File: rtl/crypto_insn_encoder.sv
// Request-driven RV32I / Zknh-SHA256 instruction encoder with a registered issue port.
// Op 15 expands into SHA256SUM0, SUM1, SIG0, SIG1 on consecutive destination registers.
module crypto_insn_encoder #(
  parameter int          CNT_W    = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [11:0]      req_imm,
  output logic             insn_valid,
  input  logic             insn_ready,
  output logic [31:0]      insn,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic [0:0]       state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [4:0]       rd_base_q, rd_base_d;
  logic [4:0]       rs1_base_q, rs1_base_d;
  logic [31:0]      insn_q, insn_d;
  logic             insn_valid_q, insn_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        out_free;
  logic        req_fire;
  logic        load_en;
  logic [31:0] load_word;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;

  function automatic logic [31:0] sha_word(input logic [1:0] sel,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1);
    return {7'b0001000, 3'b000, sel, rs1, 3'b001, rd, OPC_OP_IMM};
  endfunction

  assign out_free  = !insn_valid_q || insn_ready;
  assign req_ready = (state_q == ST_IDLE) && out_free;
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    r_funct3 = 3'b000;
    case (req_op)
      5'd2:    r_funct3 = 3'b001;
      5'd3:    r_funct3 = 3'b010;
      5'd4:    r_funct3 = 3'b011;
      5'd5:    r_funct3 = 3'b100;
      5'd6:    r_funct3 = 3'b101;
      5'd7:    r_funct3 = 3'b101;
      5'd8:    r_funct3 = 3'b110;
      5'd9:    r_funct3 = 3'b111;
      default: r_funct3 = 3'b000;
    endcase
    r_funct7 = (req_op == 5'd1 || req_op == 5'd7) ? 7'b0100000 : 7'b0000000;
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    rd_base_d    = rd_base_q;
    rs1_base_d   = rs1_base_q;
    insn_d       = insn_q;
    insn_valid_d = insn_valid_q;
    err_d        = 1'b0;
    cnt_d        = cnt_q;
    load_en      = 1'b0;
    load_word    = NOP_WORD;

    // A take with nothing new to load drops back to the idle NOP word.
    if (insn_valid_q && insn_ready) begin
      insn_valid_d = 1'b0;
      insn_d       = NOP_WORD;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          if (req_op <= 5'd9) begin
            load_en   = 1'b1;
            load_word = {r_funct7, req_rs2, req_rs1, r_funct3, req_rd, OPC_OP};
          end else if (req_op == 5'd10) begin
            load_en   = 1'b1;
            load_word = {req_imm, req_rs1, 3'b000, req_rd, OPC_OP_IMM};
          end else if (req_op <= 5'd14) begin
            // ops 11..14 map to sel 0..3; low two bits plus one does that mod 4
            load_en   = 1'b1;
            load_word = sha_word(req_op[1:0] + 2'd1, req_rd, req_rs1);
          end else if (req_op == 5'd15) begin
            load_en    = 1'b1;
            load_word  = sha_word(2'd0, req_rd, req_rs1);
            rd_base_d  = req_rd;
            rs1_base_d = req_rs1;
            k_d        = 2'd1;
            state_d    = ST_EXPAND;
          end else begin
            err_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (out_free) begin
          load_en   = 1'b1;
          load_word = sha_word(k_q, rd_base_q + {3'b000, k_q}, rs1_base_q);
          k_d       = k_q + 2'd1;
          if (k_q == 2'd3) state_d = ST_IDLE;
        end
      end
    endcase

    if (load_en) begin
      insn_d       = load_word;
      insn_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      rd_base_q    <= 5'd0;
      rs1_base_q   <= 5'd0;
      insn_q       <= NOP_WORD;
      insn_valid_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      rd_base_q    <= rd_base_d;
      rs1_base_q   <= rs1_base_d;
      insn_q       <= insn_d;
      insn_valid_q <= insn_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign insn        = insn_q;
  assign insn_valid  = insn_valid_q;
  assign busy        = (state_q == ST_EXPAND);
  assign err         = err_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_crypto_insn_encoder.sv
// Directed bench for crypto_insn_encoder: single ops, macro expansion, backpressure,
// illegal-op saturation and asynchronous reset in the middle of a macro.
module tb_crypto_insn_encoder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [11:0] req_imm = '0;
  logic        insn_valid;
  logic        insn_ready = 1'b1;
  logic [31:0] insn;
  logic        busy;
  logic        err;
  logic [7:0]  illegal_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crypto_insn_encoder #(.CNT_W(8), .NOP_WORD(32'h00000013)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .insn_valid  (insn_valid),
    .insn_ready  (insn_ready),
    .insn        (insn),
    .busy        (busy),
    .err         (err),
    .illegal_cnt (illegal_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [11:0] imm, input logic [31:0] exp);
    @(negedge clk);
    req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_eq({tag, "_valid"}, {31'd0, insn_valid}, 32'd1);
    check_eq(tag, insn, exp);
    $display("issue %s op=%0d insn=%h", tag, op, insn);
    @(posedge clk);
    #1;
    check_eq({tag, "_valid_clr"}, {31'd0, insn_valid}, 32'd0);
    check_eq({tag, "_nop"}, insn, NOP);
  endtask

  task automatic start_macro(input logic [4:0] rd, input logic [4:0] rs1);
    @(negedge clk);
    req_op = 5'd15; req_rd = rd; req_rs1 = rs1; req_rs2 = 5'd0; req_imm = 12'd0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  logic [31:0] mac_a [4] = '{32'h10059F13, 32'h10159F93, 32'h10259013, 32'h10359093};
  logic [31:0] mac_b [4] = '{32'h10019113, 32'h10119193, 32'h10219213, 32'h10319293};

  initial begin
    int err_seen;
    int valid_seen;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, insn_valid}, 32'd0);
    check_eq("rst_insn", insn, NOP);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single ops
    issue("add",   5'd0,  5'd3,  5'd1,  5'd2,  12'h000, 32'h002081B3);
    issue("sub",   5'd1,  5'd5,  5'd6,  5'd7,  12'h000, 32'h407302B3);
    issue("sra",   5'd7,  5'd1,  5'd2,  5'd3,  12'h000, 32'h403150B3);
    issue("and",   5'd9,  5'd31, 5'd31, 5'd31, 12'h000, 32'h01FFFFB3);
    issue("sltu0", 5'd4,  5'd0,  5'd4,  5'd5,  12'h000, 32'h00523033);
    issue("addi",  5'd10, 5'd1,  5'd0,  5'd9,  12'hFFF, 32'hFFF00093);
    issue("sum0",  5'd11, 5'd10, 5'd11, 5'd3,  12'h000, 32'h10059513);
    issue("sig1",  5'd14, 5'd10, 5'd11, 5'd3,  12'h000, 32'h10359513);

    // macro with rd wrap, continuous ready
    start_macro(5'd30, 5'd11);
    check_eq("mac_w0", insn, mac_a[0]);
    check_eq("mac_busy0", {31'd0, busy}, 32'd1);
    check_eq("mac_ready0", {31'd0, req_ready}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("mac_w%0d", i), insn, mac_a[i]);
      check_eq($sformatf("mac_v%0d", i), {31'd0, insn_valid}, 32'd1);
      check_eq($sformatf("mac_busy%0d", i), {31'd0, busy}, (i == 3) ? 32'd0 : 32'd1);
      check_eq($sformatf("mac_ready%0d", i), {31'd0, req_ready}, (i == 3) ? 32'd1 : 32'd0);
    end
    $display("macro rd=30 rs1=11 done insn=%h", insn);
    @(posedge clk);
    #1 check_eq("mac_end_valid", {31'd0, insn_valid}, 32'd0);

    // macro under backpressure, with a request offered during expansion
    start_macro(5'd2, 5'd3);
    check_eq("bp_w0", insn, mac_b[0]);
    insn_ready = 1'b0;
    req_op = 5'd0; req_rd = 5'd3; req_rs1 = 5'd1; req_rs2 = 5'd2;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("bp_hold%0d", i), insn, mac_b[0]);
      check_eq($sformatf("bp_ready%0d", i), {31'd0, req_ready}, 32'd0);
      check_eq($sformatf("bp_busy%0d", i), {31'd0, busy}, 32'd1);
    end
    insn_ready = 1'b1;
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("bp_w%0d", i), insn, mac_b[i]);
      check_eq($sformatf("bp_v%0d", i), {31'd0, insn_valid}, 32'd1);
    end
    $display("macro rd=2 rs1=3 backpressured done insn=%h", insn);
    @(posedge clk);
    #1;
    check_eq("bp_end_valid", {31'd0, insn_valid}, 32'd0);
    check_eq("bp_end_insn", insn, NOP);

    // illegal ops: 300 back-to-back accepts
    @(negedge clk);
    req_op = 5'd20; req_rd = 5'd1; req_rs1 = 5'd1; req_rs2 = 5'd1;
    req_valid = 1'b1;
    err_seen = 0;
    valid_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (err) err_seen++;
      if (insn_valid) valid_seen++;
      if (i == 9)   check_eq("ill_cnt10", {24'd0, illegal_cnt}, 32'd10);
      if (i == 254) check_eq("ill_cnt255", {24'd0, illegal_cnt}, 32'd255);
    end
    req_valid = 1'b0;
    check_eq("ill_err_pulses", err_seen, 32'd300);
    check_eq("ill_no_valid", valid_seen, 32'd0);
    @(posedge clk);
    #1;
    check_eq("ill_err_clr", {31'd0, err}, 32'd0);
    check_eq("ill_cnt_sat", {24'd0, illegal_cnt}, 32'd255);
    $display("illegal burst done cnt=%0d err_pulses=%0d", illegal_cnt, err_seen);

    // asynchronous reset mid-macro, after word 1
    start_macro(5'd7, 5'd1);
    check_eq("ar_w0", insn, 32'h10009393);
    @(posedge clk);
    #1 check_eq("ar_w1", insn, 32'h10109413);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_valid", {31'd0, insn_valid}, 32'd0);
    check_eq("ar_insn", insn, NOP);
    check_eq("ar_busy", {31'd0, busy}, 32'd0);
    check_eq("ar_cnt", {24'd0, illegal_cnt}, 32'd0);
    $display("async reset mid-macro insn=%h busy=%0d", insn, busy);
    @(negedge clk);
    rst = 1'b0;
    issue("add_post_rst", 5'd0, 5'd3, 5'd1, 5'd2, 12'h000, 32'h002081B3);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
